// File: rtl/alisim_pkg.sv
// Shared types and constants for the alignment simulator datapath.
// Nucleotide encodings, row geometry, LFSR taps and sampler FSM states.
package alisim_pkg;

  localparam int ROW_W  = 40;
  localparam int PROB_W = 10;

  localparam logic [1:0] NUC_A = 2'b00;
  localparam logic [1:0] NUC_C = 2'b01;
  localparam logic [1:0] NUC_G = 2'b10;
  localparam logic [1:0] NUC_T = 2'b11;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } samp_state_e;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_MASK : 32'h0);
  endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit right-shift Galois LFSR with load and single-step control.
// A zero load value is replaced by SEED so the register never locks up.
module lfsr32
  import alisim_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        step,
  output logic [31:0] state
);

  logic [31:0] state_q;
  logic [31:0] state_d;

  // next state: load wins, otherwise advance once per step
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (load_val == 32'h0) ? SEED : load_val;
    end else if (step) begin
      state_d = lfsr_next(state_q);
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/nucl_sampler.sv
// Per-site child nucleotide sampler: one lane per cycle through a single
// threshold comparator, producing a packed 2-bit-per-site alignment word.
module nucl_sampler
  import alisim_pkg::*;
#(
  parameter int          LANES  = 16,
  parameter int          PROB_W = 10,
  parameter logic [31:0] SEED   = 32'hACE1_2024
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*ROW_W-1:0] rows,
  input  logic                   seed_load,
  input  logic [31:0]            seed,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*LANES-1:0]     out_nucl,
  output logic                   out_err
);

  localparam int KW = $clog2(LANES);
  localparam logic [KW-1:0] LAST = KW'(LANES - 1);

  samp_state_e state_q, state_d;

  logic [LANES*ROW_W-1:0] rows_q, rows_d;
  logic [KW-1:0]          k_q, k_d;
  logic [2*LANES-1:0]     nucl_q, nucl_d;
  logic                   err_q, err_d;

  logic        lfsr_load;
  logic        lfsr_step;
  logic [31:0] lfsr_state;

  logic [3*PROB_W-1:0] thr;
  logic [PROB_W-1:0]   c0, c1, c2, r;
  logic [1:0]          child;
  logic                lane_bad;
  logic                unused_lfsr_hi;

  lfsr32 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (lfsr_load),
    .load_val(seed),
    .step    (lfsr_step),
    .state   (lfsr_state)
  );

  assign unused_lfsr_hi = ^lfsr_state[31:PROB_W];

  // lane-k thresholds against the current draw; one comparator set
  always_comb begin
    thr = rows_q[int'(k_q)*ROW_W + PROB_W +: 3*PROB_W];
    c0  = thr[3*PROB_W-1 -: PROB_W];
    c1  = thr[2*PROB_W-1 -: PROB_W];
    c2  = thr[PROB_W-1:0];
    r   = lfsr_state[PROB_W-1:0];
    if (r < c0) begin
      child = NUC_A;
    end else if (r < c1) begin
      child = NUC_C;
    end else if (r < c2) begin
      child = NUC_G;
    end else begin
      child = NUC_T;
    end
    lane_bad = (c0 > c1) || (c1 > c2);
  end

  // batch sequencing: accept, walk the lanes, hold the result
  always_comb begin
    state_d   = state_q;
    rows_d    = rows_q;
    k_d       = k_q;
    nucl_d    = nucl_q;
    err_d     = err_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    unique case (state_q)
      IDLE: begin
        lfsr_load = seed_load;
        if (in_valid) begin
          rows_d  = rows;
          k_d     = '0;
          nucl_d  = '0;
          err_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        nucl_d[int'(k_q)*2 +: 2] = child;
        err_d     = err_q | lane_bad;
        lfsr_step = 1'b1;
        k_d       = k_q + 1'b1;
        if (k_q == LAST) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // datapath and state registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rows_q  <= '0;
      k_q     <= '0;
      nucl_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      k_q     <= k_d;
      nucl_q  <= nucl_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign out_nucl  = nucl_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_nucl_sampler.sv
// Self-checking bench for nucl_sampler against a lane-by-lane
// reference model of the sampling rules and LFSR sequence.
module tb_nucl_sampler;

  localparam logic [31:0] SEED = 32'hACE1_2024;
  localparam logic [31:0] MASK = 32'h8020_0003;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [639:0] rows = '0;
  logic         seed_load = 1'b0;
  logic [31:0]  seed = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_nucl;
  logic         out_err;

  nucl_sampler dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .rows     (rows),
    .seed_load(seed_load),
    .seed     (seed),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_nucl (out_nucl),
    .out_err  (out_err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] m_lfsr = SEED;
  logic [31:0] exp_nucl = '0;
  logic        exp_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lstep(input logic [31:0] s);
    logic [31:0] t;
    t = s >> 1;
    if (s[0]) t = t ^ MASK;
    return t;
  endfunction

  // reference: sample all 16 lanes from the current model LFSR
  function automatic void model(input logic [639:0] rr);
    int c0, c1, c2, x, ch;
    exp_nucl = '0;
    exp_err  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      c0 = int'(rr[i*40+30 +: 10]);
      c1 = int'(rr[i*40+20 +: 10]);
      c2 = int'(rr[i*40+10 +: 10]);
      x  = int'(m_lfsr[9:0]);
      if (x < c0) ch = 0;
      else if (x < c1) ch = 1;
      else if (x < c2) ch = 2;
      else ch = 3;
      exp_nucl[2*i +: 2] = 2'(ch);
      if (c0 > c1 || c1 > c2) exp_err = 1'b1;
      m_lfsr = lstep(m_lfsr);
    end
  endfunction

  function automatic logic [39:0] mkrow(input int a, input int b, input int c);
    logic [39:0] w;
    w = {10'(a), 10'(b), 10'(c), 10'h0};
    return w;
  endfunction

  function automatic logic [639:0] rand_rows(input bit mono);
    logic [639:0] v;
    int a, b, c, t;
    v = '0;
    for (int i = 0; i < 16; i++) begin
      a = int'($urandom_range(0, 1023));
      b = int'($urandom_range(0, 1023));
      c = int'($urandom_range(0, 1023));
      if (mono) begin
        if (a > b) begin t = a; a = b; b = t; end
        if (b > c) begin t = b; b = c; c = t; end
        if (a > b) begin t = a; a = b; b = t; end
      end
      v[i*40 +: 40] = mkrow(a, b, c);
      v[i*40 +: 10] = 10'($urandom);
    end
    return v;
  endfunction

  // every cycle a batch is presented, it must match the model
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      check("hold_nucl", out_nucl, exp_nucl);
      check("hold_err", 32'(out_err), 32'(exp_err));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
  end

  task automatic wait_ready();
    int i = 0;
    while (!in_ready && i < 40) begin
      @(negedge clk);
      i++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
  endtask

  task automatic idle_seed(input logic [31:0] sd);
    wait_ready();
    seed_load = 1'b1;
    seed = sd;
    m_lfsr = (sd == 32'h0) ? SEED : sd;
    @(posedge clk);
    @(negedge clk);
    seed_load = 1'b0;
  endtask

  // one batch; abort7 pulses reset once k has reached 7
  task automatic run_batch(input logic [639:0] rr, input bit ld,
                           input logic [31:0] sd, input int hold,
                           input bit run_seed, input bit abort7,
                           output logic [31:0] got_nucl,
                           output logic got_err);
    got_nucl = '0;
    got_err  = 1'b0;
    wait_ready();
    in_valid  = 1'b1;
    rows      = rr;
    seed_load = ld;
    seed      = sd;
    if (ld) m_lfsr = (sd == 32'h0) ? SEED : sd;
    model(rr);
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    seed_load = 1'b0;
    rows      = rand_rows(1'b0);
    check("run_in_ready", 32'(in_ready), 32'd0);
    for (int e = 1; e <= 16; e++) begin
      if (run_seed && e == 4) begin
        seed_load = 1'b1;
        seed = 32'd5;
      end else begin
        seed_load = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      if (abort7 && e == 7) begin
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_ready", 32'(in_ready), 32'd1);
        check("abort_lfsr", dut.lfsr_state, 32'hACE1_2024);
        check("abort_nucl", out_nucl, 32'h0);
        reset_n = 1'b1;
        m_lfsr = SEED;
        return;
      end
      if (e == 15) check("valid_early", 32'(out_valid), 32'd0);
      if (e == 16) check("valid_e16", 32'(out_valid), 32'd1);
    end
    seed_load = 1'b0;
    got_nucl = out_nucl;
    got_err  = out_err;
    repeat (hold) @(negedge clk);
    check("valid_held", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("released", 32'(out_valid), 32'd0);
    check("idle_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [639:0] rr;
    logic [31:0]  gn;
    logic         ge;

    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_nucl", out_nucl, 32'h0);
    check("rst_err", 32'(out_err), 32'd0);
    check("rst_lfsr", dut.lfsr_state, 32'hACE1_2024);
    reset_n = 1'b1;
    m_lfsr = SEED;
    @(negedge clk);

    run_batch('0, 1'b0, 32'h0, 0, 1'b0, 1'b0, gn, ge);
    check("zero_nucl", gn, 32'hFFFF_FFFF);
    check("zero_err", 32'(ge), 32'd0);

    idle_seed(32'd1);
    check("seed1_lfsr", dut.lfsr_state, 32'd1);
    rr = '0;
    rr[39:0]  = mkrow(2, 0, 0);
    rr[79:40] = mkrow(2, 4, 0);
    run_batch(rr, 1'b0, 32'h0, 10, 1'b0, 1'b0, gn, ge);
    check("seed1_lane0", 32'(gn[1:0]), 32'd0);
    check("seed1_lane1", 32'(gn[3:2]), 32'd1);

    rr = '0;
    rr[5*40 +: 40] = mkrow(500, 100, 900);
    run_batch(rr, 1'b0, 32'h0, 2, 1'b0, 1'b0, gn, ge);
    check("lane5_err", 32'(ge), 32'd1);
    run_batch('0, 1'b0, 32'h0, 1, 1'b0, 1'b0, gn, ge);
    check("err_cleared", 32'(ge), 32'd0);

    run_batch(rand_rows(1'b1), 1'b0, 32'h0, 0, 1'b0, 1'b1, gn, ge);
    @(negedge clk);
    run_batch('0, 1'b0, 32'h0, 0, 1'b0, 1'b0, gn, ge);
    check("post_abort_nucl", gn, 32'hFFFF_FFFF);

    idle_seed(32'd0);
    check("seed0_lfsr", dut.lfsr_state, 32'hACE1_2024);
    run_batch(rand_rows(1'b1), 1'b0, 32'h0, 1, 1'b1, 1'b0, gn, ge);

    run_batch(rand_rows(1'b1), 1'b1, 32'h1234_5678, 0, 1'b0, 1'b0, gn, ge);

    for (int t = 0; t < 24; t++) begin
      run_batch(rand_rows(($urandom & 3) != 0), ($urandom & 3) == 0,
                $urandom, int'($urandom_range(0, 3)),
                ($urandom & 1) == 1, 1'b0, gn, ge);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nucl_sampler.md
# nucl_sampler

Samples the child nucleotide of each of 16 alignment sites from the transition-matrix rows selected for those sites' parent nucleotides. Sits directly downstream of the per-site row-selection PE. It consumes the 16 × 40-bit selected rows, draws one 10-bit pseudo-random number per site from an internal LFSR, and emits a packed 32-bit child alignment word in the same 2-bit-per-site format the PE takes as `nucl_alig`.

## Interface
- `LANES`, 16, sites per batch (fixed at 16 for this revision).
- `PROB_W`, 10, width of one cumulative threshold.
- `SEED`, 32'hACE1_2024, LFSR reset value; also substituted for a zero seed.

- `clk`  in  1  clock; one clock domain.
- `reset_n`  in  1  reset, synchronous and active-low.
- `in_valid`  in  1  batch of rows present.
- `in_ready`  out  1  block can accept a batch.
- `rows`  in  640  lane i row at `[i*40 +: 40]`.
- `seed_load`  in  1  load `seed` into the LFSR.
- `seed`  in  32  new LFSR state.
- `out_valid`  out  1  `out_nucl` holds a finished batch.
- `out_ready`  in  1  downstream accepts the batch.
- `out_nucl`  out  32  lane i child nucleotide at `[2i+1:2i]`.
- `out_err`  out  1  at least one lane in the batch had non-monotonic thresholds.

## Operation
- Row format: `c0=[39:30]` for A (00), `c1=[29:20]` for C (01), `c2=[19:10]` for G (10). Bits `[9:0]` are ignored; T (11) takes the remainder up to 1024.
- Sampling uses r = `lfsr[9:0]`:
  - child = 00 if r < c0;
  - else 01 if r < c1;
  - else 10 if r < c2;
  - else 11.
  - All comparisons are unsigned 10-bit.
- LFSR: 32-bit Galois, right-shift. next = `{1'b0,s[31:1]}` XOR (`s[0]` ? 32'h8020_0003 : 0). The state steps exactly once per processed lane and at no other time.
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid && in_ready`, capture `rows` and clear the lane counter k, the output register and the error flag. Go to RUN.
  - RUN: one lane per cycle. Write the lane-k child into `out_nucl[2k+1:2k]`. Set the error flag if c0>c1 or c1>c2. Step the LFSR and increment k. After k=15, go to HOLD.
  - HOLD: `out_valid`=1. `out_nucl` and `out_err` are stable. On `out_ready`, go to IDLE.
- `seed_load`:
  - Honoured only in IDLE. A zero `seed` loads `SEED`.
  - If `seed_load` and an input handshake coincide, the seed is loaded first and the batch uses the new seed.
  - `seed_load` is ignored in RUN and HOLD.
- `out_err` is valid only with `out_valid`. It is recomputed for every batch and is not sticky.

## Timing
- Reset values:
  - state IDLE, `in_ready`=1;
  - `out_valid`=0, `out_nucl`=0, `out_err`=0;
  - LFSR=`SEED`, k=0.
- Input handshake at clock edge E0. Lanes 0..15 are processed at edges E1..E16. `out_valid`=1 from edge E16 onward.
- Output handshake at edge Eh (`out_valid && out_ready`). The state is IDLE after Eh, with `in_ready`=1. The earliest next input handshake is Eh+1.
- Peak throughput is one batch per 18 cycles. No overlap between batches.
- `out_nucl` bits of lanes not yet processed read 0 during RUN and are not meaningful. Only HOLD contents are defined.
- Reset asserted mid-RUN or in HOLD: the batch is dropped and all registers take their reset values at that edge.
- `in_ready` is a registered function of state only. There are no combinational paths from inputs to `in_ready` or `out_valid`.

## Structure
- Shared package `alisim_pkg` holds:
  - `ROW_W`=40 and `PROB_W`=10;
  - the nucleotide encodings `NUC_A`=2'b00, `NUC_C`=2'b01, `NUC_G`=2'b10, `NUC_T`=2'b11;
  - the LFSR mask 32'h8020_0003;
  - the FSM state typedef (IDLE/RUN/HOLD).
- One sub-module, `lfsr32`, with inputs `clk`, `reset_n`, `load`, `load_val`, `step` and output `state`. It applies the zero-seed substitution internally.
- Per-lane threshold compare is combinational inside `nucl_sampler`, muxed by k. There is one comparator set, not 16.

## Test plan
- All rows zero, default seed: `out_nucl`=32'hFFFF_FFFF and `out_err`=0. `out_valid` rises 16 edges after the input handshake.
- `seed_load` with `seed`=1 in IDLE, then a batch with lane0 c0=2 and lane1 {c0=2, c1=4}. Lane 0 draws r=1, giving 00. Lane 1 draws r=3 (state 32'h8020_0003), giving 01.
- Hold `out_ready`=0 for 10 cycles after `out_valid`. `out_valid`, `out_nucl` and `out_err` stay constant and `in_ready` stays 0. The batch is released one edge after `out_ready`=1.
- Lane 5 row {c0=500, c1=100, c2=900}, others zero: `out_err`=1. The next batch, with all rows zero, gives `out_err`=0.
- Assert `reset_n`=0 for one cycle during RUN at k=7. The next cycle shows `out_valid`=0, `in_ready`=1 and LFSR=32'hACE1_2024. A fresh batch then reproduces the first scenario.
- Apply `seed_load` with `seed`=0 in IDLE: the LFSR becomes `SEED`. Apply `seed_load` with `seed`=5 during RUN: it is ignored and the sample sequence is unchanged.
